// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
// Size encodings, FSM states and byte-count lookup.
package lsu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  function automatic logic [2:0] size_to_bytes(size_e s);
    logic [2:0] n;
    unique case (s)
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
// Purely combinational; word-size loads pass through unchanged.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     word,
  input  size_e           size,
  input  logic            zero_ext,
  output logic [XLEN-1:0] data
);

  logic sb;
  logic sh;

  assign sb = ~zero_ext & word[7];
  assign sh = ~zero_ext & word[15];

  always_comb begin
    data = '0;
    unique case (size)
      SZ_BYTE: data = {{(XLEN-8){sb}}, word[7:0]};
      SZ_HALF: data = {{(XLEN-16){sh}}, word[15:0]};
      default: data = XLEN'(word);
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Load/store unit serialising byte/half/word requests onto a byte RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests.
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  output logic [XLEN-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [7:0]               ram_dout,
  output logic                     ram_wr_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [7:0]               ram_din
);

  lsu_state_e               state;
  logic                     we;
  size_e                    size;
  logic                     zero_ext;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [31:0]              wdata;
  logic [31:0]              data;
  logic [1:0]               cnt;

  size_e                    req_sz;
  logic                     misalign;
  logic                     req_err;
  logic                     last;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [31:0]              data_next;
  logic [XLEN-1:0]          ext_data;
  logic                     unused_addr;

  assign req_sz = size_e'(req_size);
  assign unused_addr = ^req_addr[XLEN-1:ADDRESS_WIDTH];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign =
    (req_sz == SZ_HALF && req_addr[0]) ||
    (req_sz == SZ_WORD && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_sz == SZ_RSVD) || misalign;
  assign last = ({1'b0, cnt} == size_to_bytes(size) - 3'd1);

  // Address wraps naturally at the RAM size.
  assign addr = base + ADDRESS_WIDTH'(cnt);

  assign ram_rd_en   = (state == ACCESS) && !we;
  assign ram_wr_en   = (state == ACCESS) && we;
  assign ram_rd_addr = addr;
  assign ram_wr_addr = addr;
  assign ram_din     = wdata[{cnt, 3'b000} +: BYTE_W];

  // Merge the byte arriving this cycle so the last one is extended too.
  always_comb begin
    data_next = data;
    data_next[{cnt, 3'b000} +: BYTE_W] = ram_dout;
  end

  lsu_load_extend #(
    .XLEN(XLEN)
  ) u_ext (
    .word    (data_next),
    .size    (size),
    .zero_ext(zero_ext),
    .data    (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we         <= 1'b0;
      size       <= SZ_BYTE;
      zero_ext   <= 1'b0;
      base       <= '0;
      wdata      <= '0;
      data       <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we        <= req_we;
            size      <= req_sz;
            zero_ext  <= req_unsigned;
            base      <= req_addr[ADDRESS_WIDTH-1:0];
            wdata     <= req_wdata[31:0];
            data      <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we) data <= data_next;
          if (last) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we ? '0 : ext_data;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
